// File: rtl/seg_scan_mux_if.sv
// Pattern inputs and scan outputs of the multiplexed seven-segment driver.
// The slave side is the driver and the master side is its user.
interface seg_scan_mux_if #(
    parameter int DIGITS = 5,
    parameter int SEG_W  = 8
);
    logic [DIGITS*SEG_W-1:0] seg_in;
    logic [DIGITS-1:0]       digit_en;
    logic [SEG_W-1:0]        seg_out;
    logic [DIGITS-1:0]       sel_out;
    logic                    frame_tick;

    modport master (
        output seg_in,
        output digit_en,
        input  seg_out,
        input  sel_out,
        input  frame_tick
    );

    modport slave (
        input  seg_in,
        input  digit_en,
        output seg_out,
        output sel_out,
        output frame_tick
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed digit scanner: each digit owns DIV cycles, starting with BLANK dark cycles.
// Its pattern and enable are latched once per slot, so the displayed digit cannot tear.
module seg_scan_mux #(
    parameter int DIGITS         = 5,
    parameter int SEG_W          = 8,
    parameter int DIV            = 1000,
    parameter int BLANK          = 8,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input logic           clk,
    input logic           rst_n,
    seg_scan_mux_if.slave bus
);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_IDLE  = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SEG_W-1:0]  pat_q, pat_d;
    logic              en_q, en_d;
    logic [SEG_W-1:0]  seg_out_q, seg_out_d;
    logic [DIGITS-1:0] sel_out_q, sel_out_d;
    logic              tick_q, tick_d;
    logic [DIGITS-1:0] hot_s;
    logic [SEG_W-1:0]  pat_sel_s;
    logic              en_sel_s;
    logic              sample_s;
    logic              visible_s;

    // Slot counter and digit index advance
    always_comb begin
        idx_d = idx_q;
        if (div_cnt_q == CNT_LAST) begin
            div_cnt_d = {CNT_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
        end
    end

    // Select the upcoming digit's pattern and enable via a one-hot AND-OR mux
    always_comb begin
        hot_s     = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;
        pat_sel_s = {SEG_W{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            pat_sel_s = pat_sel_s | (bus.seg_in[i*SEG_W +: SEG_W] & {SEG_W{hot_s[i]}});
        end
        en_sel_s = |(bus.digit_en & hot_s);
    end

    assign sample_s = (div_cnt_d == CNT_BLANK);

    generate
        if (BLANK == 0) begin : g_no_blank
            assign visible_s = 1'b1;
        end else begin : g_blank
            assign visible_s = (div_cnt_d >= CNT_BLANK);
        end
    endgenerate

    // Latch the slot's pattern, then derive the outputs from the post-edge counters
    always_comb begin
        if (sample_s) begin
            pat_d = pat_sel_s;
            en_d  = en_sel_s;
        end else begin
            pat_d = pat_q;
            en_d  = en_q;
        end
        if (visible_s && en_d) begin
            seg_out_d = pat_d;
            sel_out_d = hot_s ^ SEL_IDLE;
        end else begin
            seg_out_d = {SEG_W{1'b0}};
            sel_out_d = SEL_IDLE;
        end
        tick_d = (div_cnt_d == {CNT_W{1'b0}}) && (idx_d == {IDX_W{1'b0}});
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= {CNT_W{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            pat_q     <= {SEG_W{1'b0}};
            en_q      <= 1'b0;
            seg_out_q <= {SEG_W{1'b0}};
            sel_out_q <= SEL_IDLE;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            pat_q     <= pat_d;
            en_q      <= en_d;
            seg_out_q <= seg_out_d;
            sel_out_q <= sel_out_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.seg_out    = seg_out_q;
    assign bus.sel_out    = sel_out_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: a 5-digit active-low instance and an 8-digit active-high instance
// with no blanking, checked against vector tables, hand sequences and a slot-arithmetic model.
module tb_seg_scan_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seg_scan_mux_if #(.DIGITS(5), .SEG_W(8)) bus_a ();
    seg_scan_mux_if #(.DIGITS(8), .SEG_W(8)) bus_b ();

    seg_scan_mux #(.DIGITS(5), .SEG_W(8), .DIV(4), .BLANK(1), .SEL_ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    seg_scan_mux #(.DIGITS(8), .SEG_W(8), .DIV(3), .BLANK(0), .SEL_ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    int checks = 0;
    int errors = 0;

    int         k_a, k_b;
    logic [7:0] lp_a, lp_b;
    logic       le_a, le_b;
    logic [7:0] es_a, esl_a, es_b, esl_b;
    logic       et_a, et_b;

    typedef struct {
        logic [4:0] en;
        logic [4:0] sel;
        logic [7:0] seg;
        logic       tick;
    } vec_t;
    vec_t tbl[40];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: after k edges since reset release, slot = k/dv, cycle in slot = k%dv.
    task automatic model_step(input int nd, input int dv, input int bl, input bit al, input int k,
                              input logic [63:0] seg, input logic [7:0] en,
                              inout logic [7:0] lpat, inout logic len,
                              output logic [7:0] eseg, output logic [7:0] esel, output logic etick);
        int cnt;
        int idx;
        logic [7:0] hot;
        logic [7:0] mask;
        bit vis;
        cnt = k % dv;
        idx = (k / dv) % nd;
        if (cnt == bl) begin
            lpat = seg[idx*8 +: 8];
            len  = en[idx];
        end
        vis   = (cnt >= bl) && len;
        hot   = vis ? (8'h01 << idx) : 8'h00;
        mask  = (nd >= 8) ? 8'hFF : ((8'h01 << nd) - 8'h01);
        esel  = (al ? ~hot : hot) & mask;
        eseg  = vis ? lpat : 8'h00;
        etick = (cnt == 0) && (idx == 0) && (k > 0);
    endtask

    task automatic step();
        k_a++;
        k_b++;
        model_step(5, 4, 1, 1'b1, k_a, 64'(bus_a.seg_in), 8'(bus_a.digit_en), lp_a, le_a, es_a, esl_a, et_a);
        model_step(8, 3, 0, 1'b0, k_b, bus_b.seg_in, bus_b.digit_en, lp_b, le_b, es_b, esl_b, et_b);
        @(posedge clk);
        #1;
        check("a_seg_model", 32'(bus_a.seg_out), 32'(es_a));
        check("a_sel_model", 32'(bus_a.sel_out), 32'(esl_a));
        check("a_tick_model", 32'(bus_a.frame_tick), 32'(et_a));
        check("b_seg_model", 32'(bus_b.seg_out), 32'(es_b));
        check("b_sel_model", 32'(bus_b.sel_out), 32'(esl_b));
        check("b_tick_model", 32'(bus_b.frame_tick), 32'(et_b));
        check("b_sel_onehot", 32'($countones(bus_b.sel_out) <= 1), 32'(1));
    endtask

    // Assert reset mid-cycle, check the asynchronous effect, release on a falling edge.
    task automatic do_reset(input int hold);
        #2 rst_n = 1'b0;
        #1;
        check("rst_a_sel", 32'(bus_a.sel_out), 32'(5'b11111));
        check("rst_a_seg", 32'(bus_a.seg_out), 32'(8'h00));
        check("rst_a_tick", 32'(bus_a.frame_tick), 32'(1'b0));
        check("rst_b_sel", 32'(bus_b.sel_out), 32'(8'h00));
        check("rst_b_seg", 32'(bus_b.seg_out), 32'(8'h00));
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k_a = 0;
        k_b = 0;
        lp_a = 8'h00;
        lp_b = 8'h00;
        le_a = 1'b0;
        le_b = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] slot_sel[5];
        logic [7:0] slot_seg[5];
        int kk, s, c, ticks, last, adj;
        logic prev;

        slot_sel = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
        slot_seg = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
        for (int n = 0; n < 40; n++) begin
            kk = n + 1;
            s  = (kk / 4) % 5;
            c  = kk % 4;
            tbl[n].en = (n < 20) ? 5'b11111 : 5'b11011;
            if (c == 0 || (n >= 20 && s == 2)) begin
                tbl[n].sel = 5'b11111;
                tbl[n].seg = 8'h00;
            end else begin
                tbl[n].sel = slot_sel[s];
                tbl[n].seg = slot_seg[s];
            end
            tbl[n].tick = (kk % 20 == 0);
        end

        bus_a.seg_in   = {8'h54, 8'h43, 8'h32, 8'h21, 8'h10};
        bus_a.digit_en = 5'b11111;
        bus_b.seg_in   = 64'h8877_6655_4433_2211;
        bus_b.digit_en = 8'hFF;
        do_reset(2);

        // Scan order over one frame, then a frame with digit 2 disabled
        for (int n = 0; n < 40; n++) begin
            bus_a.digit_en = tbl[n].en;
            step();
            check("tbl_sel", 32'(bus_a.sel_out), 32'(tbl[n].sel));
            check("tbl_seg", 32'(bus_a.seg_out), 32'(tbl[n].seg));
            check("tbl_tick", 32'(bus_a.frame_tick), 32'(tbl[n].tick));
        end

        // Digit 1 changes during its visible cycle 2: current slot holds, next frame shows it
        bus_a.digit_en = 5'b11111;
        while (k_a < 46) step();
        bus_a.seg_in[15:8] = 8'hFF;
        step();
        check("tear_hold", 32'(bus_a.seg_out), 32'(8'h21));
        while (k_a < 65) step();
        check("tear_next", 32'(bus_a.seg_out), 32'(8'hFF));
        check("tear_next_sel", 32'(bus_a.sel_out), 32'(5'b11101));

        // Reset dropped at slot 2 cycle 3, then slot 0 restarts
        while (k_a % 20 != 11) step();
        do_reset(2);
        check("rel_blank_sel", 32'(bus_a.sel_out), 32'(5'b11111));
        step();
        check("rel_first_sel", 32'(bus_a.sel_out), 32'(5'b11110));
        check("rel_first_seg", 32'(bus_a.seg_out), 32'(8'h10));
        check("rel_no_tick", 32'(bus_a.frame_tick), 32'(1'b0));

        // Frame tick spacing over 100 free-running cycles
        ticks = 0;
        last  = 0;
        adj   = 0;
        prev  = 1'b0;
        repeat (100) begin
            step();
            if (bus_a.frame_tick) begin
                ticks++;
                check("tick_spacing", 32'(k_a - last), 32'(20));
                last = k_a;
            end
            if (prev && bus_a.frame_tick) adj++;
            prev = bus_a.frame_tick;
        end
        check("tick_count", 32'(ticks), 32'(5));
        check("tick_adjacent", 32'(adj), 32'(0));

        // Random patterns and enables changing at arbitrary points, with one random reset
        for (int r = 0; r < 400; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus_a.seg_in   = {$urandom(), $urandom()} >> 24;
                bus_a.digit_en = 5'($urandom());
                bus_b.seg_in   = {$urandom(), $urandom()};
                bus_b.digit_en = 8'($urandom());
            end
            if (r == 200) do_reset(1 + $urandom_range(0, 2));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
